// File: rtl/pc_seq_ctrl_pkg.sv
// pc_seq_ctrl_pkg: shared state encoding, opcodes and PC-select codes for the
// fetch/sequence controller and the PC datapath.
`default_nettype none

package pc_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_UPDATE = 3'd4,
    ST_HALT   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_JMP = 2'b10;

  function automatic logic branch_taken(input logic [5:0] op, input logic zero);
    if (op == OP_BEQ) return zero;
    if (op == OP_BNE) return !zero;
    return 1'b0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_seq_ctrl_fetch_timeout_ctr.sv
// ============================================================================
// fetch_timeout_ctr: 8-bit wait counter; expired flags the last allowed cycle.
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_timeout_ctr #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] c_LAST = 8'(LIMIT - 1);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + 8'd1;
    end
  end

  // High while the current wait cycle is the LIMIT-th one without an ack.
  assign expired = (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/pc_seq_ctrl.sv
// ============================================================================
// pc_seq_ctrl: fetch/decode/execute sequencer driving PC select and write.
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] ir,
  output logic        ex_start,
  input  logic        ex_done,
  input  logic        alu_zero,
  input  logic        halt_req,
  output logic [1:0]  pc_sel,
  output logic        pc_we,
  output logic        halted,
  output logic        fetch_err,
  output logic [31:0] instret
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_ir;
  logic [31:0] r_instret;
  logic        r_jump;
  logic        r_taken;
  logic        r_fetch_err;
  logic        w_is_jump;
  logic        w_expired;
  logic        w_ctr_clear;
  logic        w_ctr_en;

  assign w_is_jump   = (r_ir[31:26] == OP_J);
  assign w_ctr_clear = (r_state != ST_FETCH) || imem_ack;
  assign w_ctr_en    = (r_state == ST_FETCH) && !imem_ack;

  fetch_timeout_ctr #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_ctr_clear),
    .en     (w_ctr_en),
    .expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          w_next = ST_DECODE;
        end else if (w_expired) begin
          w_next = ST_ERROR;
        end
      end
      ST_DECODE: w_next = w_is_jump ? ST_UPDATE : ST_EXEC;
      ST_EXEC:   if (ex_done) w_next = ST_UPDATE;
      ST_UPDATE: w_next = halt_req ? ST_HALT : ST_FETCH;
      ST_HALT:   if (!halt_req) w_next = ST_FETCH;
      ST_ERROR:  w_next = ST_ERROR;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req = (r_state == ST_FETCH);
    ex_start = (r_state == ST_DECODE) && !w_is_jump;
    pc_we    = (r_state == ST_UPDATE);
    halted   = (r_state == ST_HALT);
  end

  // Jump and taken bits are exclusive, so pc_sel never shows 2'b11.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir        <= '0;
      r_instret   <= '0;
      r_jump      <= 1'b0;
      r_taken     <= 1'b0;
      r_fetch_err <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (imem_ack) begin
            r_ir <= imem_data;
          end else if (w_expired) begin
            r_fetch_err <= 1'b1;
          end
        end
        ST_DECODE: begin
          r_jump  <= w_is_jump;
          r_taken <= 1'b0;
        end
        ST_EXEC: begin
          if (ex_done) begin
            r_taken <= branch_taken(r_ir[31:26], alu_zero);
          end
        end
        ST_UPDATE: r_instret <= r_instret + 32'd1;
        default: ;
      endcase
    end
  end

  assign ir        = r_ir;
  assign instret   = r_instret;
  assign fetch_err = r_fetch_err;
  assign pc_sel    = {r_jump, r_taken};

endmodule

`default_nettype wire

// File: tb/tb_pc_seq_ctrl.sv
// ============================================================================
// tb_pc_seq_ctrl: randomized bench for pc_seq_ctrl against a transaction model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_seq_ctrl;

  localparam logic [5:0] T_OP_J   = 6'b000010;
  localparam logic [5:0] T_OP_BEQ = 6'b000100;
  localparam logic [5:0] T_OP_BNE = 6'b000101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] ir;
  logic        ex_start;
  logic        ex_done;
  logic        alu_zero;
  logic        halt_req;
  logic [1:0]  pc_sel;
  logic        pc_we;
  logic        halted;
  logic        fetch_err;
  logic [31:0] instret;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_instret = 32'd0;

  pc_seq_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .imem_req (imem_req),
    .imem_ack (imem_ack),
    .imem_data(imem_data),
    .ir       (ir),
    .ex_start (ex_start),
    .ex_done  (ex_done),
    .alu_zero (alu_zero),
    .halt_req (halt_req),
    .pc_sel   (pc_sel),
    .pc_we    (pc_we),
    .halted   (halted),
    .fetch_err(fetch_err),
    .instret  (instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Where the PC goes once an instruction has resolved.
  function automatic logic [1:0] exp_sel(input logic [5:0] op, input logic z);
    if (op == T_OP_J)   return 2'b10;
    if (op == T_OP_BEQ) return z ? 2'b01 : 2'b00;
    if (op == T_OP_BNE) return z ? 2'b00 : 2'b01;
    return 2'b00;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},     32'(imem_req), 32'd0);
    chk({tag, "_start"},   32'(ex_start), 32'd0);
    chk({tag, "_we"},      32'(pc_we), 32'd0);
    chk({tag, "_halted"},  32'(halted), 32'd0);
    chk({tag, "_ferr"},    32'(fetch_err), 32'd0);
    chk({tag, "_pcsel"},   32'(pc_sel), 32'd0);
    chk({tag, "_ir"},      ir, 32'd0);
    chk({tag, "_instret"}, instret, 32'd0);
  endtask

  // Release reset between edges, then expect IDLE followed by FETCH.
  task automatic release_reset();
    rst_n = 1'b1;
    exp_instret = 32'd0;
    chk("idle_noreq", 32'(imem_req), 32'd0);
    step();
    chk("first_fetch", 32'(imem_req), 32'd1);
  endtask

  // One instruction: w memory wait cycles, ex_done on EXEC cycle d, zero flag z.
  task automatic run_instr(input logic [31:0] instr, input int w, input int d,
                           input logic z, input logic h);
    int   cur;
    int   e;
    int   starts;
    int   lat;
    int   n_hold;
    bit   got;
    logic [5:0] op;
    op = instr[31:26];
    halt_req = h;
    chk("fetch_req", 32'(imem_req), 32'd1);
    for (int i = 0; i < w; i++) begin
      imem_ack  = 1'b0;
      ex_done   = 1'($urandom);
      alu_zero  = 1'($urandom);
      step();
      chk("wait_req", 32'(imem_req), 32'd1);
    end
    imem_ack  = 1'b1;
    imem_data = instr;
    ex_done   = 1'($urandom);
    step();
    cur = w + 2;
    e = -1;
    starts = 0;
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      if (ex_start) starts++;
      if (pc_we) begin
        got = 1'b1;
        lat = cur;
        break;
      end
      if (e >= 0) begin
        ex_done  = (e == d);
        alu_zero = (e == d) ? z : 1'($urandom);
        e++;
      end else begin
        ex_done  = 1'($urandom);
        alu_zero = 1'($urandom);
      end
      if (ex_start) e = 0;
      imem_ack  = 1'($urandom);
      imem_data = $urandom;
      step();
      cur++;
    end
    if (!got) begin
      chk("we_timeout", 32'd0, 32'd1);
    end else begin
      chk("latency", lat, (op == T_OP_J) ? (w + 3) : (w + 4 + d));
      chk("pc_sel", 32'(pc_sel), 32'(exp_sel(op, z)));
      chk("ex_start_cnt", starts, (op == T_OP_J) ? 0 : 1);
      chk("ir", ir, instr);
      chk("instret_pre", instret, exp_instret);
    end
    exp_instret = exp_instret + 32'd1;
    imem_ack = 1'b0;
    ex_done  = 1'b0;
    step();
    chk("pc_we_once", 32'(pc_we), 32'd0);
    chk("instret", instret, exp_instret);
    if (h) begin
      chk("halted", 32'(halted), 32'd1);
      chk("halt_noreq", 32'(imem_req), 32'd0);
      n_hold = $urandom_range(0, 2);
      for (int i = 0; i < n_hold; i++) step();
      chk("halt_hold", 32'(halted), 32'd1);
      halt_req = 1'b0;
      step();
      chk("resume_req", 32'(imem_req), 32'd1);
      chk("resume_halted", 32'(halted), 32'd0);
    end else begin
      chk("next_fetch", 32'(imem_req), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] instr;
    logic [5:0]  op;
    int          kind;

    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_data = 32'd0;
    ex_done = 1'b0;
    alu_zero = 1'b0;
    halt_req = 1'b0;
    #1;
    chk_all_zero("rst");
    repeat (3) step();
    release_reset();

    // Directed instructions from the test plan.
    run_instr(32'h0800_0010, 0, 0, 1'b0, 1'b0);
    run_instr(32'h1000_0003, 0, 1, 1'b1, 1'b0);
    run_instr(32'h1000_0003, 0, 1, 1'b0, 1'b0);
    run_instr(32'h1400_0003, 0, 1, 1'b1, 1'b0);
    run_instr(32'h1400_0003, 0, 1, 1'b0, 1'b0);
    run_instr(32'h0000_0020, 0, 0, 1'b0, 1'b0);
    run_instr(32'h0000_0020, 2, 3, 1'b1, 1'b1);

    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: op = T_OP_J;
        1: op = T_OP_BEQ;
        2: op = T_OP_BNE;
        default: begin
          op = 6'($urandom);
          while (op == T_OP_J || op == T_OP_BEQ || op == T_OP_BNE) op = 6'($urandom);
        end
      endcase
      instr = {op, 26'($urandom)};
      run_instr(instr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom), ($urandom_range(0, 4) == 0));
    end

    // Reset dropped while EXEC waits for ex_done.
    imem_ack = 1'b1;
    imem_data = 32'h1000_0003;
    step();
    imem_ack = 1'b0;
    ex_done = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midexec");
    step();
    chk("midexec_we", 32'(pc_we), 32'd0);
    release_reset();

    // Fetch timeout: 16 cycles with no ack land in ERROR.
    imem_ack = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("to_wait_req", 32'(imem_req), 32'd1);
      chk("to_wait_ferr", 32'(fetch_err), 32'd0);
    end
    step();
    chk("to_ferr", 32'(fetch_err), 32'd1);
    chk("to_noreq", 32'(imem_req), 32'd0);
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1'($urandom);
      imem_data = $urandom;
      ex_done = 1'($urandom);
      step();
      chk("err_we", 32'(pc_we), 32'd0);
      chk("err_ferr", 32'(fetch_err), 32'd1);
      chk("err_req", 32'(imem_req), 32'd0);
    end
    imem_ack = 1'b0;
    ex_done = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("err_rst");
    step();
    release_reset();
    run_instr(32'h0800_0010, 1, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
